// File: rtl/reg_bus_arb.sv
// Two-requester arbiter (jtag m0, host m1) in front of a single shared register bus.
// Serves one transaction at a time. A read waits RD_LATENCY cycles for reg_rd_data.
module reg_bus_arb #(
    parameter int unsigned RD_LATENCY = 1,
    parameter bit          RR_EN      = 1'b1
) (
    input  logic        reg_clk,
    input  logic        nrst,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [7:0]  m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_ack,
    output logic [15:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [7:0]  m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_ack,
    output logic [15:0] m1_rdata,
    output logic [7:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_wr_en,
    output logic        reg_rd_en,
    input  logic [15:0] reg_rd_data,
    output logic [1:0]  grant,
    output logic        busy
);

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RD_WAIT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;   // 0 = m0, 1 = m1
    logic            prio_q, prio_d;     // requester favoured on a tie
    logic            wr_q, wr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            wr_en_q, wr_en_d;
    logic            rd_en_q, rd_en_d;
    logic            ack0_q, ack0_d;
    logic            ack1_q, ack1_d;
    logic [DW-1:0]   rdata0_q, rdata0_d;
    logic [DW-1:0]   rdata1_q, rdata1_d;
    logic [1:0]      grant_q, grant_d;
    logic            busy_q, busy_d;
    logic            pick;

    // State and output registers
    always_ff @(posedge reg_clk) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            prio_q   <= 1'b0;
            wr_q     <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            grant_q  <= 2'b00;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            prio_q   <= prio_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_en_q  <= wr_en_d;
            rd_en_q  <= rd_en_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic; outputs are computed one cycle early so they land registered
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        prio_d   = prio_q;
        wr_d     = wr_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_en_d  = 1'b0;
        rd_en_d  = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        grant_d  = grant_q;
        busy_d   = busy_q;
        pick     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (m0_req && m1_req) begin
                    pick = RR_EN ? prio_q : 1'b0;
                end else begin
                    pick = m1_req;
                end
                if (m0_req || m1_req) begin
                    owner_d = pick;
                    wr_d    = pick ? m1_wr    : m0_wr;
                    addr_d  = pick ? m1_addr  : m0_addr;
                    wdata_d = pick ? m1_wdata : m0_wdata;
                    wr_en_d = wr_d;
                    rd_en_d = !wr_d;
                    grant_d = pick ? 2'b10 : 2'b01;
                    busy_d  = 1'b1;
                    if (RR_EN) begin
                        prio_d = !pick;
                    end
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (wr_q) begin
                    ack0_d  = !owner_q;
                    ack1_d  = owner_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = CW'(RD_LATENCY);
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (cnt_q == CW'(1)) begin
                    if (owner_q) begin
                        rdata1_d = reg_rd_data;
                    end else begin
                        rdata0_d = reg_rd_data;
                    end
                    ack0_d  = !owner_q;
                    ack1_d  = owner_q;
                    state_d = S_DONE;
                end
                cnt_d = cnt_q - CW'(1);
            end
            S_DONE: begin
                grant_d = 2'b00;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign m0_ack    = ack0_q;
    assign m1_ack    = ack1_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_wr_en = wr_en_q;
    assign reg_rd_en = rd_en_q;
    assign grant     = grant_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_reg_bus_arb.sv
// Directed bench for reg_bus_arb: a round-robin instance with RD_LATENCY=3 plus a
// fixed-priority instance driven by the same inputs.
module tb_reg_bus_arb;

    logic        clk;
    logic        nrst;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [7:0]  m0_addr, m1_addr;
    logic [15:0] m0_wdata, m1_wdata, reg_rd_data;

    logic        m0_ack, m1_ack, reg_wr_en, reg_rd_en, busy;
    logic [15:0] m0_rdata, m1_rdata, reg_wdata;
    logic [7:0]  reg_addr;
    logic [1:0]  grant;

    logic        f_m0_ack, f_m1_ack, f_reg_wr_en, f_reg_rd_en, f_busy;
    logic [15:0] f_m0_rdata, f_m1_rdata, f_reg_wdata;
    logic [7:0]  f_reg_addr;
    logic [1:0]  f_grant;

    int n_vec = 0;
    int n_err = 0;

    reg_bus_arb #(.RD_LATENCY(3), .RR_EN(1'b1)) u_rr (
        .reg_clk(clk), .nrst(nrst),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr_en(reg_wr_en),
        .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
        .grant(grant), .busy(busy)
    );

    reg_bus_arb #(.RD_LATENCY(3), .RR_EN(1'b0)) u_fix (
        .reg_clk(clk), .nrst(nrst),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(f_m0_ack), .m0_rdata(f_m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(f_m1_ack), .m1_rdata(f_m1_rdata),
        .reg_addr(f_reg_addr), .reg_wdata(f_reg_wdata), .reg_wr_en(f_reg_wr_en),
        .reg_rd_en(f_reg_rd_en), .reg_rd_data(reg_rd_data),
        .grant(f_grant), .busy(f_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        nrst = 1'b0;
        m0_req = 1'b0; m0_wr = 1'b0; m0_addr = 8'h00; m0_wdata = 16'h0000;
        m1_req = 1'b0; m1_wr = 1'b0; m1_addr = 8'h00; m1_wdata = 16'h0000;
        reg_rd_data = 16'hDEAD;
        tick();
        tick();

        // reset state
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_reg_addr", 32'(reg_addr), 32'h0);
        chk("rst_reg_wdata", 32'(reg_wdata), 32'h0);
        chk("rst_strobes", 32'({reg_wr_en, reg_rd_en}), 32'h0);
        chk("rst_acks", 32'({m0_ack, m1_ack}), 32'h0);
        chk("rst_m0_rdata", 32'(m0_rdata), 32'h0);
        chk("rst_m1_rdata", 32'(m1_rdata), 32'h0);
        nrst = 1'b1;
        tick();

        // m0 write 0x05 <- 0xA5A5
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 8'h05; m0_wdata = 16'hA5A5;
        tick();
        chk("wr_strobe", 32'({reg_wr_en, reg_rd_en}), 32'h2);
        chk("wr_addr", 32'(reg_addr), 32'h05);
        chk("wr_wdata", 32'(reg_wdata), 32'hA5A5);
        chk("wr_grant_n1", 32'(grant), 32'h1);
        chk("wr_busy_n1", 32'(busy), 32'h1);
        chk("wr_no_early_ack", 32'(m0_ack), 32'h0);
        tick();
        chk("wr_ack", 32'({m0_ack, m1_ack}), 32'h2);
        chk("wr_grant_n2", 32'(grant), 32'h1);
        chk("wr_strobe_off", 32'(reg_wr_en), 32'h0);
        m0_req = 1'b0;
        tick();
        chk("wr_idle_grant", 32'(grant), 32'h0);
        chk("wr_idle_busy", 32'(busy), 32'h0);
        chk("wr_ack_off", 32'(m0_ack), 32'h0);
        chk("hold_addr", 32'(reg_addr), 32'h05);
        chk("hold_wdata", 32'(reg_wdata), 32'hA5A5);

        // m1 read 0x02, data presented 3 cycles after the strobe
        m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 8'h02;
        tick();
        chk("rd_strobe", 32'({reg_wr_en, reg_rd_en}), 32'h1);
        chk("rd_addr", 32'(reg_addr), 32'h02);
        chk("rd_grant", 32'(grant), 32'h2);
        tick();
        chk("rd_strobe_off", 32'(reg_rd_en), 32'h0);
        chk("rd_busy", 32'(busy), 32'h1);
        tick();
        chk("rd_wait_ack", 32'(m1_ack), 32'h0);
        tick();
        reg_rd_data = 16'h1234;
        chk("rd_wait_ack2", 32'(m1_ack), 32'h0);
        tick();
        reg_rd_data = 16'hDEAD;
        chk("rd_ack", 32'({m0_ack, m1_ack}), 32'h1);
        chk("rd_m1_rdata", 32'(m1_rdata), 32'h1234);
        chk("rd_m0_rdata_kept", 32'(m0_rdata), 32'h0);
        chk("rd_fix_m1_rdata", 32'(f_m1_rdata), 32'h1234);
        m1_req = 1'b0;
        tick();
        chk("rd_idle_busy", 32'(busy), 32'h0);
        chk("rd_hold_rdata", 32'(m1_rdata), 32'h1234);

        // both requesting continuously: RR alternates, fixed priority keeps m0
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 8'h40; m0_wdata = 16'h0040;
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 8'h41; m1_wdata = 16'h0041;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_grant", 32'(grant), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("rr_addr", 32'(reg_addr), (i % 2 == 0) ? 32'h40 : 32'h41);
            chk("fix_grant", 32'(f_grant), 32'h1);
            tick();
            chk("rr_ack", 32'({m0_ack, m1_ack}), (i % 2 == 0) ? 32'h2 : 32'h1);
            chk("fix_ack", 32'({f_m0_ack, f_m1_ack}), 32'h2);
            tick();
            chk("rr_gap_grant", 32'(grant), 32'h0);
            chk("rr_gap_busy", 32'(busy), 32'h0);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        chk("rr_quiet", 32'(busy), 32'h0);

        // reset while waiting for read data
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 8'h33;
        tick();
        chk("rst_rd_strobe", 32'(reg_rd_en), 32'h1);
        tick();
        chk("rst_rd_busy", 32'(busy), 32'h1);
        nrst = 1'b0; m0_req = 1'b0;
        tick();
        chk("rst_mid_grant", 32'(grant), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        nrst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_mid_no_ack", 32'({m0_ack, m1_ack}), 32'h0);
            chk("rst_mid_quiet", 32'({busy, reg_rd_en, reg_wr_en}), 32'h0);
            tick();
        end

        // reset in the sampling cycle: strobe must never fire
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 8'h77; nrst = 1'b0;
        tick();
        chk("rst_pre_strobe", 32'({reg_wr_en, busy}), 32'h0);
        nrst = 1'b1; m1_req = 1'b0;
        tick();
        chk("rst_pre_strobe2", 32'({reg_wr_en, busy}), 32'h0);

        // address change after latching is ignored
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 8'h10; m0_wdata = 16'h1111;
        tick();
        chk("lat_addr", 32'(reg_addr), 32'h10);
        chk("lat_strobe", 32'(reg_wr_en), 32'h1);
        m0_addr = 8'h20; m0_wr = 1'b0;
        tick();
        chk("lat_addr_held", 32'(reg_addr), 32'h10);
        chk("lat_ack", 32'({m0_ack, m1_ack}), 32'h2);
        chk("lat_grant", 32'(grant), 32'h1);
        m0_req = 1'b0;
        tick();
        chk("lat_end", 32'({busy, reg_wr_en, reg_rd_en}), 32'h0);
        chk("lat_end_addr", 32'(reg_addr), 32'h10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
